// File: rtl/memory_arbiter.sv
// Two-requester arbiter serialising CONTROL (req0) and an auxiliary port (req1) onto MAIN_MEMORY.
// Optional ACK watchdog: define MEMORY_ARBITER_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module memory_arbiter #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       MEMORY_ARBITER_CLOCK_50,
    input  logic                       MEMORY_ARBITER_ResetInHigh_In,
    input  logic [1:0]                 MEMORY_ARBITER_ReqRD_InBus,
    input  logic [1:0]                 MEMORY_ARBITER_ReqWR_InBus,
    input  logic [2*DATAWIDTH_BUS-1:0] MEMORY_ARBITER_ReqA_InBus,
    input  logic [2*DATAWIDTH_BUS-1:0] MEMORY_ARBITER_ReqB_InBus,
    output logic [1:0]                 MEMORY_ARBITER_ReqACK_OutBus,
    output logic [1:0]                 MEMORY_ARBITER_ReqErr_OutBus,
    output logic                       MEMORY_ARBITER_RD_Out,
    output logic                       MEMORY_ARBITER_WRMain_Out,
    output logic [DATAWIDTH_BUS-1:0]   MEMORY_ARBITER_A_OutBus,
    output logic [DATAWIDTH_BUS-1:0]   MEMORY_ARBITER_B_OutBus,
    input  logic                       MEMORY_ARBITER_ACK_In,
    input  logic [DATAWIDTH_BUS-1:0]   MEMORY_ARBITER_Data_InBus,
    output logic [DATAWIDTH_BUS-1:0]   MEMORY_ARBITER_Data_OutBus,
    output logic [1:0]                 MEMORY_ARBITER_Grant_OutBus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("memory_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]               state;
    logic                     last_grant;
    logic                     op_err;

    logic [1:0]               pending;
    logic                     win_idx;
    logic [1:0]               win_onehot;
    logic                     win_wr;
    logic                     win_conflict;
    logic [DATAWIDTH_BUS-1:0] win_a;
    logic [DATAWIDTH_BUS-1:0] win_b;

    logic                     owner;
    logic                     ack_hit;
    logic                     wdog_fire;
    logic                     access_done;
    logic                     done_err;

    // Arbitration decode: on a tie the requester not served last wins.
    always_comb begin
        pending      = MEMORY_ARBITER_ReqRD_InBus | MEMORY_ARBITER_ReqWR_InBus;
        win_idx      = (pending == 2'b11) ? ~last_grant : pending[1];
        win_onehot   = win_idx ? 2'b10 : 2'b01;
        win_wr       = MEMORY_ARBITER_ReqWR_InBus[win_idx];
        win_conflict = MEMORY_ARBITER_ReqRD_InBus[win_idx] & MEMORY_ARBITER_ReqWR_InBus[win_idx];
        win_a        = win_idx ? MEMORY_ARBITER_ReqA_InBus[2*DATAWIDTH_BUS-1:DATAWIDTH_BUS]
                               : MEMORY_ARBITER_ReqA_InBus[DATAWIDTH_BUS-1:0];
        win_b        = win_idx ? MEMORY_ARBITER_ReqB_InBus[2*DATAWIDTH_BUS-1:DATAWIDTH_BUS]
                               : MEMORY_ARBITER_ReqB_InBus[DATAWIDTH_BUS-1:0];
    end

    assign owner       = MEMORY_ARBITER_Grant_OutBus[1];
    assign ack_hit     = (state == ST_ACCESS) && MEMORY_ARBITER_ACK_In;
    assign access_done = ack_hit | wdog_fire;
    // A real ACK reports only the RD+WR conflict; a watchdog expiry is always an error.
    assign done_err    = ack_hit ? op_err : 1'b1;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt;

    always_ff @(posedge MEMORY_ARBITER_CLOCK_50) begin
        if (MEMORY_ARBITER_ResetInHigh_In || (state != ST_ACCESS) || access_done) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_fire = (state == ST_ACCESS) && !MEMORY_ARBITER_ACK_In && (wdog_cnt == WDOG_LAST);
`else
    assign wdog_fire = 1'b0;
`endif

    always_ff @(posedge MEMORY_ARBITER_CLOCK_50) begin
        if (MEMORY_ARBITER_ResetInHigh_In) begin
            state                        <= ST_IDLE;
            last_grant                   <= 1'b1;
            op_err                       <= 1'b0;
            MEMORY_ARBITER_RD_Out        <= 1'b0;
            MEMORY_ARBITER_WRMain_Out    <= 1'b0;
            MEMORY_ARBITER_ReqACK_OutBus <= 2'b00;
            MEMORY_ARBITER_ReqErr_OutBus <= 2'b00;
            MEMORY_ARBITER_Grant_OutBus  <= 2'b00;
            MEMORY_ARBITER_A_OutBus      <= '0;
            MEMORY_ARBITER_B_OutBus      <= '0;
            MEMORY_ARBITER_Data_OutBus   <= '0;
        end else begin
            MEMORY_ARBITER_ReqACK_OutBus <= 2'b00;
            MEMORY_ARBITER_ReqErr_OutBus <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        state                       <= ST_ACCESS;
                        MEMORY_ARBITER_Grant_OutBus <= win_onehot;
                        MEMORY_ARBITER_A_OutBus     <= win_a;
                        MEMORY_ARBITER_B_OutBus     <= win_b;
                        MEMORY_ARBITER_RD_Out       <= ~win_wr;
                        MEMORY_ARBITER_WRMain_Out   <= win_wr;
                        op_err                      <= win_conflict;
                    end
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        state                        <= ST_RELEASE;
                        MEMORY_ARBITER_RD_Out        <= 1'b0;
                        MEMORY_ARBITER_WRMain_Out    <= 1'b0;
                        MEMORY_ARBITER_ReqACK_OutBus <= MEMORY_ARBITER_Grant_OutBus;
                        MEMORY_ARBITER_ReqErr_OutBus <= done_err ? MEMORY_ARBITER_Grant_OutBus : 2'b00;
                        last_grant                   <= owner;
                        if (ack_hit && MEMORY_ARBITER_RD_Out) begin
                            MEMORY_ARBITER_Data_OutBus <= MEMORY_ARBITER_Data_InBus;
                        end
                    end
                end
                ST_RELEASE: begin
                    state                       <= ST_IDLE;
                    MEMORY_ARBITER_Grant_OutBus <= 2'b00;
                end
                default: begin
                    state                       <= ST_IDLE;
                    MEMORY_ARBITER_RD_Out       <= 1'b0;
                    MEMORY_ARBITER_WRMain_Out   <= 1'b0;
                    MEMORY_ARBITER_Grant_OutBus <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: scenario tasks plus a completion scoreboard.
`timescale 1ns/1ps
module tb_memory_arbiter;
    localparam int W  = 32;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_rd, req_wr;
    logic [2*W-1:0] req_a, req_b;
    logic [1:0]     req_ack, req_err;
    logic           rd_out, wr_out;
    logic [W-1:0]   a_out, b_out;
    logic           ack_in;
    logic [W-1:0]   data_in, data_out;
    logic [1:0]     grant;

    typedef struct packed {
        logic [1:0]   ack;
        logic [1:0]   err;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] exp_data;
    int           n_checks = 0;
    int           n_pass   = 0;
    bit           mon_en   = 1'b0;

    memory_arbiter #(.DATAWIDTH_BUS(W), .TIMEOUT_CYCLES(TO)) dut (
        .MEMORY_ARBITER_CLOCK_50      (clk),
        .MEMORY_ARBITER_ResetInHigh_In(rst),
        .MEMORY_ARBITER_ReqRD_InBus   (req_rd),
        .MEMORY_ARBITER_ReqWR_InBus   (req_wr),
        .MEMORY_ARBITER_ReqA_InBus    (req_a),
        .MEMORY_ARBITER_ReqB_InBus    (req_b),
        .MEMORY_ARBITER_ReqACK_OutBus (req_ack),
        .MEMORY_ARBITER_ReqErr_OutBus (req_err),
        .MEMORY_ARBITER_RD_Out        (rd_out),
        .MEMORY_ARBITER_WRMain_Out    (wr_out),
        .MEMORY_ARBITER_A_OutBus      (a_out),
        .MEMORY_ARBITER_B_OutBus      (b_out),
        .MEMORY_ARBITER_ACK_In        (ack_in),
        .MEMORY_ARBITER_Data_InBus    (data_in),
        .MEMORY_ARBITER_Data_OutBus   (data_out),
        .MEMORY_ARBITER_Grant_OutBus  (grant)
    );

    always #5 clk = ~clk;

    // Completion scoreboard and bus invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ((rd_out & wr_out) !== 1'b0) $display("FAIL strobe_exclusive: rd=%b wr=%b, required not both high", rd_out, wr_out); else n_pass++;
            n_checks++;
            if (!(grant === 2'b00 || grant === 2'b01 || grant === 2'b10)) $display("FAIL grant_onehot: got %b, required 00/01/10", grant); else n_pass++;
            n_checks++;
            if ((rd_out | wr_out) && grant === 2'b00) $display("FAIL strobe_without_grant: rd=%b wr=%b grant=%b", rd_out, wr_out, grant); else n_pass++;
            if (req_ack !== 2'b00) begin
                exp_t e;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_ack: got ack=%b err=%b, required no ACK", req_ack, req_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({req_ack, req_err, data_out} !== {e.ack, e.err, e.data})
                        $display("FAIL sb_completion: got ack=%b err=%b data=%h, required ack=%b err=%b data=%h",
                                 req_ack, req_err, data_out, e.ack, e.err, e.data);
                    else n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_rd = 2'b00; req_wr = 2'b00; req_a = '0; req_b = '0;
        ack_in = 1'b0; data_in = '0;
        tick(); tick();
        n_checks++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b required 00", grant); else n_pass++;
        n_checks++; if (rd_out !== 1'b0) $display("FAIL rst_rd: got %b required 0", rd_out); else n_pass++;
        n_checks++; if (wr_out !== 1'b0) $display("FAIL rst_wr: got %b required 0", wr_out); else n_pass++;
        n_checks++; if (req_ack !== 2'b00) $display("FAIL rst_ack: got %b required 00", req_ack); else n_pass++;
        n_checks++; if (req_err !== 2'b00) $display("FAIL rst_err: got %b required 00", req_err); else n_pass++;
        n_checks++; if (a_out !== '0) $display("FAIL rst_a: got %h required 0", a_out); else n_pass++;
        n_checks++; if (b_out !== '0) $display("FAIL rst_b: got %h required 0", b_out); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL rst_data: got %h required 0", data_out); else n_pass++;
        rst = 1'b0; exp_data = '0; mon_en = 1'b1;
        tick();
        n_checks++; if (grant !== 2'b00) $display("FAIL idle_no_req_grant: got %b required 00", grant); else n_pass++;
    endtask

    task automatic test_read();
        req_a = {32'h0000_0999, 32'h0000_0010}; req_rd = 2'b01;
        exp_q.push_back(exp_t'{2'b01, 2'b00, 32'hCAFE_F00D});
        tick();
        n_checks++; if (rd_out !== 1'b1) $display("FAIL read_strobe_start: got %b required 1", rd_out); else n_pass++;
        n_checks++; if (wr_out !== 1'b0) $display("FAIL read_no_wr: got %b required 0", wr_out); else n_pass++;
        n_checks++; if (a_out !== 32'h10) $display("FAIL read_addr: got %h required 00000010", a_out); else n_pass++;
        n_checks++; if (grant !== 2'b01) $display("FAIL read_grant: got %b required 01", grant); else n_pass++;
        req_a[W-1:0] = 32'h0000_0077;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (rd_out !== 1'b1) $display("FAIL read_strobe_hold: got %b required 1", rd_out); else n_pass++;
            n_checks++; if (a_out !== 32'h10) $display("FAIL read_addr_latched: got %h required 00000010", a_out); else n_pass++;
        end
        ack_in = 1'b1; data_in = 32'hCAFE_F00D;
        tick();
        n_checks++; if (rd_out !== 1'b0) $display("FAIL read_strobe_drop: got %b required 0", rd_out); else n_pass++;
        n_checks++; if (req_ack !== 2'b01) $display("FAIL read_ack: got %b required 01", req_ack); else n_pass++;
        n_checks++; if (data_out !== 32'hCAFE_F00D) $display("FAIL read_data: got %h required cafef00d", data_out); else n_pass++;
        n_checks++; if (grant !== 2'b01) $display("FAIL release_grant: got %b required 01", grant); else n_pass++;
        exp_data = 32'hCAFE_F00D; req_rd = 2'b00; ack_in = 1'b0; data_in = 32'h1111_1111;
        tick();
        n_checks++; if (grant !== 2'b00) $display("FAIL read_idle_grant: got %b required 00", grant); else n_pass++;
        n_checks++; if (req_ack !== 2'b00) $display("FAIL read_ack_width: got %b required 00", req_ack); else n_pass++;
        ack_in = 1'b1; data_in = 32'h1234_5678;
        tick();
        n_checks++; if (data_out !== exp_data) $display("FAIL stray_ack_data: got %h required %h", data_out, exp_data); else n_pass++;
        ack_in = 1'b0;
    endtask

    task automatic test_rw_conflict();
        req_a = {32'h0000_0040, 32'h0}; req_b = {32'h0000_0005, 32'hFFFF_FFFF};
        req_rd = 2'b10; req_wr = 2'b10;
        exp_q.push_back(exp_t'{2'b10, 2'b10, exp_data});
        tick();
        n_checks++; if (wr_out !== 1'b1) $display("FAIL conflict_wr: got %b required 1", wr_out); else n_pass++;
        n_checks++; if (rd_out !== 1'b0) $display("FAIL conflict_rd: got %b required 0", rd_out); else n_pass++;
        n_checks++; if (b_out !== 32'h5) $display("FAIL conflict_b: got %h required 00000005", b_out); else n_pass++;
        n_checks++; if (a_out !== 32'h40) $display("FAIL conflict_a: got %h required 00000040", a_out); else n_pass++;
        n_checks++; if (grant !== 2'b10) $display("FAIL conflict_grant: got %b required 10", grant); else n_pass++;
        ack_in = 1'b1; data_in = 32'hDEAD_BEEF;
        tick();
        n_checks++; if (req_ack !== 2'b10) $display("FAIL conflict_ack: got %b required 10", req_ack); else n_pass++;
        n_checks++; if (req_err !== 2'b10) $display("FAIL conflict_err: got %b required 10", req_err); else n_pass++;
        n_checks++; if (data_out !== exp_data) $display("FAIL write_keeps_data: got %h required %h", data_out, exp_data); else n_pass++;
        req_rd = 2'b00; req_wr = 2'b00; ack_in = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0]   g;
        logic [W-1:0] ea, eb;
        rst = 1'b1; tick(); rst = 1'b0; exp_data = '0;
        req_a = {32'h0000_0200, 32'h0000_0100}; req_b = {32'h0000_0022, 32'h0000_0011};
        req_wr = 2'b11; req_rd = 2'b00;
        for (int k = 0; k < 4; k++) begin
            g  = (k % 2 == 0) ? 2'b01 : 2'b10;
            ea = (k % 2 == 0) ? 32'h100 : 32'h200;
            eb = (k % 2 == 0) ? 32'h11 : 32'h22;
            exp_q.push_back(exp_t'{g, 2'b00, exp_data});
            tick();
            n_checks++; if (grant !== g) $display("FAIL b2b_grant[%0d]: got %b required %b", k, grant, g); else n_pass++;
            n_checks++; if ({wr_out, a_out, b_out} !== {1'b1, ea, eb}) $display("FAIL b2b_bus[%0d]: got wr=%b a=%h b=%h required wr=1 a=%h b=%h", k, wr_out, a_out, b_out, ea, eb); else n_pass++;
            ack_in = 1'b1;
            tick();
            n_checks++; if ({req_ack, grant, wr_out} !== {g, g, 1'b0}) $display("FAIL b2b_release[%0d]: got ack=%b grant=%b wr=%b required ack=%b grant=%b wr=0", k, req_ack, grant, wr_out, g, g); else n_pass++;
            ack_in = 1'b0;
            tick();
            n_checks++; if (grant !== 2'b00) $display("FAIL b2b_idle_gap[%0d]: got %b required 00", k, grant); else n_pass++;
            if (k == 3) req_wr = 2'b00;
        end
        tick();
        n_checks++; if (grant !== 2'b00) $display("FAIL b2b_stop: got %b required 00", grant); else n_pass++;
    endtask

    task automatic test_reset_abort();
        req_a = {32'h0000_0300, 32'h0000_0020}; req_b = {32'h0, 32'h0000_1234}; req_wr = 2'b01;
        exp_q.push_back(exp_t'{2'b01, 2'b00, exp_data});
        tick();
        n_checks++; if (grant !== 2'b01) $display("FAIL solo_grant: got %b required 01", grant); else n_pass++;
        ack_in = 1'b1; tick(); ack_in = 1'b0; req_wr = 2'b00; tick();
        req_rd = 2'b10;
        tick();
        n_checks++; if ({rd_out, grant} !== {1'b1, 2'b10}) $display("FAIL abort_access: got rd=%b grant=%b required rd=1 grant=10", rd_out, grant); else n_pass++;
        tick();
        rst = 1'b1; ack_in = 1'b1; data_in = 32'hAAAA_5555;
        tick();
        n_checks++; if ({rd_out, wr_out} !== 2'b00) $display("FAIL abort_strobes: got rd=%b wr=%b required 0 0", rd_out, wr_out); else n_pass++;
        n_checks++; if (req_ack !== 2'b00) $display("FAIL abort_no_ack: got %b required 00", req_ack); else n_pass++;
        n_checks++; if (grant !== 2'b00) $display("FAIL abort_grant: got %b required 00", grant); else n_pass++;
        rst = 1'b0; ack_in = 1'b0; req_rd = 2'b00; exp_data = '0;
        tick();
        n_checks++; if (req_ack !== 2'b00) $display("FAIL abort_ack_after: got %b required 00", req_ack); else n_pass++;
        req_wr = 2'b11;
        exp_q.push_back(exp_t'{2'b01, 2'b00, exp_data});
        tick();
        n_checks++; if (grant !== 2'b01) $display("FAIL tie_after_reset: got %b required 01", grant); else n_pass++;
        ack_in = 1'b1; tick(); ack_in = 1'b0; req_wr = 2'b00; tick();
    endtask

    task automatic test_timeout();
        req_a = {32'h0, 32'h0000_0030}; req_rd = 2'b01;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        exp_q.push_back(exp_t'{2'b01, 2'b01, exp_data});
        tick();
        for (int i = 0; i < TO; i++) begin
            n_checks++; if ({rd_out, req_ack} !== 3'b100) $display("FAIL wdog_wait[%0d]: got rd=%b ack=%b required rd=1 ack=00", i, rd_out, req_ack); else n_pass++;
            tick();
        end
        n_checks++; if ({rd_out, req_ack, req_err} !== 5'b0_01_01) $display("FAIL wdog_fire: got rd=%b ack=%b err=%b required rd=0 ack=01 err=01", rd_out, req_ack, req_err); else n_pass++;
        n_checks++; if (data_out !== exp_data) $display("FAIL wdog_data: got %h required %h", data_out, exp_data); else n_pass++;
        req_rd = 2'b00; tick();
        req_rd = 2'b01;
        exp_q.push_back(exp_t'{2'b01, 2'b00, 32'h5A5A_5A5A});
        tick(); tick(); tick(); tick();
        ack_in = 1'b1; data_in = 32'h5A5A_5A5A;
        tick();
        n_checks++; if ({req_ack, req_err} !== 4'b01_00) $display("FAIL wdog_ack_tie: got ack=%b err=%b required ack=01 err=00", req_ack, req_err); else n_pass++;
        exp_data = 32'h5A5A_5A5A;
`else
        tick();
        for (int i = 0; i < 3 * TO; i++) begin
            n_checks++; if ({rd_out, req_ack} !== 3'b100) $display("FAIL wait_forever[%0d]: got rd=%b ack=%b required rd=1 ack=00", i, rd_out, req_ack); else n_pass++;
            tick();
        end
        ack_in = 1'b1; data_in = 32'h0BAD_BEEF;
        exp_q.push_back(exp_t'{2'b01, 2'b00, 32'h0BAD_BEEF});
        tick();
        n_checks++; if ({rd_out, req_ack, req_err} !== 5'b0_01_00) $display("FAIL late_ack: got rd=%b ack=%b err=%b required rd=0 ack=01 err=00", rd_out, req_ack, req_err); else n_pass++;
        exp_data = 32'h0BAD_BEEF;
`endif
        req_rd = 2'b00; ack_in = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        test_reset();
        test_read();
        test_rw_conflict();
        test_back_to_back();
        test_reset_abort();
        test_timeout();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain: got %0d outstanding completions required 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: MEMORY_ARBITER

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, sets the address and data width of every memory-side bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, sets the ACK watchdog limit in cycles; it is used only when MEMORY_ARBITER_TIMEOUT_EN is defined.
REQ-003 Clocking and reset SHALL use one clock; reset is synchronous and active-high.
REQ-004 MEMORY_ARBITER_CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-005 MEMORY_ARBITER_ResetInHigh_In  in  1  synchronous, active-high reset.
REQ-006 MEMORY_ARBITER_ReqRD_InBus  in  2  read request per requester; bit0 = CONTROL, bit1 = auxiliary port.
REQ-007 MEMORY_ARBITER_ReqWR_InBus  in  2  write request per requester.
REQ-008 MEMORY_ARBITER_ReqA_InBus  in  2*DATAWIDTH_BUS  addresses, {req1,req0}.
REQ-009 MEMORY_ARBITER_ReqB_InBus  in  2*DATAWIDTH_BUS  write data, {req1,req0}.
REQ-010 MEMORY_ARBITER_ReqACK_OutBus  out  2  one-cycle completion pulse per requester.
REQ-011 MEMORY_ARBITER_ReqErr_OutBus  out  2  error qualifier, valid only with the matching ACK bit.
REQ-012 MEMORY_ARBITER_RD_Out  out  1  read strobe to MAIN_MEMORY.
REQ-013 MEMORY_ARBITER_WRMain_Out  out  1  write strobe to MAIN_MEMORY.
REQ-014 MEMORY_ARBITER_A_OutBus  out  DATAWIDTH_BUS  latched address to MAIN_MEMORY.
REQ-015 MEMORY_ARBITER_B_OutBus  out  DATAWIDTH_BUS  latched write data to MAIN_MEMORY.
REQ-016 MEMORY_ARBITER_ACK_In  in  1  completion from MAIN_MEMORY.
REQ-017 MEMORY_ARBITER_Data_InBus  in  DATAWIDTH_BUS  read data from MAIN_MEMORY.
REQ-018 MEMORY_ARBITER_Data_OutBus  out  DATAWIDTH_BUS  last read data, shared by both requesters.
REQ-019 MEMORY_ARBITER_Grant_OutBus  out  2  one-hot owner of the memory; 00 in IDLE.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS, RELEASE.
REQ-021 Requester i is pending when ReqRD[i] or ReqWR[i] is high; the FSM samples pending requests only in IDLE.
REQ-022 With a single pending requester, that requester SHALL win; with both pending, the requester not served last (LastGrant register) SHALL win.
REQ-023 On IDLE->ACCESS the winner's A, B and operation SHALL be latched; later changes on the Req buses SHALL NOT affect the transaction.
REQ-024 In ACCESS exactly one strobe SHALL be held high with A_OutBus/B_OutBus stable, starting the cycle after the request is first sampled.
REQ-025 ReqRD[i] and ReqWR[i] high together SHALL execute as a write, with ReqErr[i]=1 at completion.
REQ-026 ACK_In sampled high in ACCESS: next cycle strobes low, ReqACK[winner]=1 for exactly one cycle, Data_OutBus loaded with Data_InBus if the operation was a read (unchanged for writes), LastGrant updated, state RELEASE.
REQ-027 ACK_In outside ACCESS SHALL be ignored.
REQ-028 RELEASE SHALL last exactly one cycle, ignore all requests, then return to IDLE; a requester SHALL drop its request in the cycle its ACK is seen.
REQ-029 Minimum turnaround SHALL be request-to-strobe 1 cycle and ACK_In-to-ReqACK 1 cycle; back-to-back grants are separated by one RELEASE cycle and one IDLE cycle.
REQ-030 MEMORY_ARBITER_RD_Out and MEMORY_ARBITER_WRMain_Out SHALL never be high together, and SHALL never be high outside ACCESS.
REQ-031 Grant_OutBus SHALL be one-hot for the winner in ACCESS and RELEASE.

Reset
REQ-032 Reset SHALL force state IDLE, strobes, ReqACK, ReqErr and Grant to 0, A/B/Data_OutBus to 0, watchdog counter to 0, and LastGrant to 1 so that requester 0 wins the first tie.
REQ-033 Reset during ACCESS SHALL abort the transaction silently: strobes low at the next edge and no ACK issued.

Configuration
REQ-034 With MEMORY_ARBITER_TIMEOUT_EN defined, a counter SHALL run in ACCESS; TIMEOUT_CYCLES cycles in ACCESS without ACK_In drop the strobes and pulse ReqACK[winner] with ReqErr[winner]=1, leave Data_OutBus unchanged, and go to RELEASE.
REQ-035 ACK_In and timeout in the same cycle SHALL complete normally with ReqErr=0.
REQ-036 Without MEMORY_ARBITER_TIMEOUT_EN, ACCESS SHALL wait indefinitely, no counter logic SHALL exist, and ReqErr is raised only per REQ-025.

Verification
REQ-037 Scenario: ReqRD=01, ReqA0=0x10, memory ACKs 3 cycles later with Data=0xCAFEF00D -> RD_Out high 3 cycles, ReqACK=01 one cycle, Data_OutBus=0xCAFEF00D, Err=00.
REQ-038 Scenario: after reset, both requesters write simultaneously, held continuously -> grants in order 01,10,01,10, each with a RELEASE+IDLE gap.
REQ-039 Scenario: ReqRD[1]=ReqWR[1]=1, ReqB1=0x5 -> WRMain_Out high, RD_Out low, B_OutBus=0x5, ReqACK=10, ReqErr=10.
REQ-040 Scenario: reset asserted on the 2nd ACCESS cycle -> strobes 0 at the next edge, ReqACK stays 00, and the next tie grants requester 0.
REQ-041 Scenario: TIMEOUT_EN defined, TIMEOUT_CYCLES=4, ACK_In held low -> strobe high exactly 4 cycles, then ReqACK=01 with ReqErr=01 and Data_OutBus unchanged; undefined -> strobe stays high.
